riscv_fetch_queue: RTL and testbench

//   Instruction-fetch stage of the RISC-V pipeline; sits directly upstream of the IF/ID register.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/riscv_fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_riscv_fetch_queue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V fetch front end.
//   PC_W_DEF / INSTR_W_DEF : default address and instruction widths
//   NOP, OP_BRANCH, OP_JAL  : instruction constants used around the fetch stage
//   fetch_entry_t           : {pc, instr} record as buffered by the prefetch queue
//   fetch_state_e           : control FSM states of riscv_fetch_queue
package riscv_pkg;

  localparam int unsigned PC_W_DEF    = 16;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    StReset,
    StRun,
    StFlush
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO used as the fetch prefetch queue.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write request and data (ignored when full and not popping)
//   pop_i             read request (ignored when empty)
//   flush_i           empties the FIFO; wins over push/pop in the same cycle
//   rdata_o           head entry (undefined content when empty)
//   count_o           number of stored entries
//   full_o, empty_o   occupancy flags
module fetch_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a push at full would need.
    do_push = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; content is only visible through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch stage: issues in-order word fetches, buffers returned words in a prefetch
// queue and hands {pc, instr, pc+4} to decode over a valid/ready handshake. A redirect flushes
// buffered and in-flight words and restarts fetching at the target.
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   imem_req, imem_addr               fetch request and 4-aligned byte address
//   imem_rdata, imem_rvalid           response, exactly one cycle after the request
//   redirect_valid, redirect_pc       taken branch/JAL from EX; target bits [1:0] ignored
//   if_valid, if_ready                head handshake towards decode
//   if_instr, if_pc, if_pc_plus4      head contents (all zero while the queue is empty)
// Optional: define RISCV_FETCH_STATS_EN to add saturating counters stat_fetched (words pushed),
//   stat_flushes (redirects) and stat_stalls (cycles with if_valid & !if_ready).
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_plus4
`ifdef RISCV_FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushes,
  output logic [31:0]        stat_stalls
`endif
);

  localparam int unsigned     CntW      = $clog2(DEPTH) + 1;
  localparam int unsigned     EntW      = PC_W + INSTR_W;
  localparam logic [PC_W-1:0] PcStep    = PC_W'(4);
  localparam logic [PC_W-1:0] AlignMask = ~PC_W'(3);
  localparam logic [PC_W-1:0] ResetPcAl = RESET_PC & AlignMask;
  localparam logic [CntW:0]   Credit    = (CntW + 1)'(DEPTH);

  fetch_state_e state_q;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            tag_q, tag_d;
  logic            epoch_q, epoch_d;

  logic [CntW:0]      pending;
  logic               issue;
  logic               push, pop;
  logic [EntW-1:0]    head;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_full, fifo_empty;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;

  fetch_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({inflight_pc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_pc    = head[EntW-1:INSTR_W];
  assign head_instr = head[INSTR_W-1:0];

  always_comb begin
    // Buffered plus in-flight words never exceed the queue depth, so a push never meets a full
    // queue without a simultaneous pop.
    pending = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    issue   = !reset && !redirect_valid && (pending < Credit);
    // Responses tagged with an older epoch belong to a flushed stream and are dropped.
    push    = !reset && !redirect_valid && imem_rvalid && inflight_q && (tag_q == epoch_q) &&
              (state_q != StFlush) && (!fifo_full || pop);
    pop     = if_valid && if_ready && !redirect_valid;

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    tag_d         = tag_q;
    inflight_d    = issue;
    epoch_d       = epoch_q ^ redirect_valid;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & AlignMask;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + PcStep;
      inflight_pc_d = fetch_pc_q;
      tag_d         = epoch_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= ResetPcAl;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      tag_q         <= 1'b0;
      epoch_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      tag_q         <= tag_d;
      epoch_q       <= epoch_d;
    end
  end

  // FLUSH marks the cycle after a redirect, when nothing of the old stream may enter the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StReset;
    end else begin
      unique case (state_q)
        StReset: state_q <= redirect_valid ? StFlush : StRun;
        StRun:   state_q <= redirect_valid ? StFlush : StRun;
        StFlush: state_q <= redirect_valid ? StFlush : StRun;
        default: state_q <= StReset;
      endcase
    end
  end

  always_comb begin
    imem_req    = issue;
    imem_addr   = reset ? ResetPcAl : fetch_pc_q;
    if_valid    = !reset && !fifo_empty;
    if_pc       = if_valid ? head_pc : '0;
    if_instr    = if_valid ? head_instr : '0;
    if_pc_plus4 = if_valid ? (head_pc + PcStep) : '0;
  end

`ifdef RISCV_FETCH_STATS_EN
  logic [31:0] fetched_q, flushes_q, stalls_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= '0;
      flushes_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (push && fetched_q != '1)           fetched_q <= fetched_q + 32'd1;
      if (redirect_valid && flushes_q != '1) flushes_q <= flushes_q + 32'd1;
      if (if_valid && !if_ready && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushes = flushes_q;
  assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
module tb_riscv_fetch_queue;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_ready;

  logic        req_a, rvalid_a, valid_a;
  logic [15:0] addr_a, pc_a, p4_a;
  logic [31:0] rdata_a, instr_a;
  logic        req_b, rvalid_b, valid_b;
  logic [15:0] addr_b, pc_b, p4_b;
  logic [31:0] rdata_b, instr_b;
`ifdef RISCV_FETCH_STATS_EN
  logic [31:0] sf_a, sfl_a, ss_a, sf_b, sfl_b, ss_b;
`endif

  riscv_fetch_queue #(.PC_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(16'h0000)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (req_a),
    .imem_addr      (addr_a),
    .imem_rdata     (rdata_a),
    .imem_rvalid    (rvalid_a),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (valid_a),
    .if_ready       (if_ready),
    .if_instr       (instr_a),
    .if_pc          (pc_a),
    .if_pc_plus4    (p4_a)
`ifdef RISCV_FETCH_STATS_EN
    ,
    .stat_fetched   (sf_a),
    .stat_flushes   (sfl_a),
    .stat_stalls    (ss_a)
`endif
  );

  riscv_fetch_queue #(.PC_W(16), .INSTR_W(32), .DEPTH(4), .RESET_PC(16'hFFF8)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (req_b),
    .imem_addr      (addr_b),
    .imem_rdata     (rdata_b),
    .imem_rvalid    (rvalid_b),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (valid_b),
    .if_ready       (if_ready),
    .if_instr       (instr_b),
    .if_pc          (pc_b),
    .if_pc_plus4    (p4_b)
`ifdef RISCV_FETCH_STATS_EN
    ,
    .stat_fetched   (sf_b),
    .stat_flushes   (sfl_b),
    .stat_stalls    (ss_b)
`endif
  );

  // Instruction memory: word at byte address 4*k holds k; responds one cycle after a request.
  always @(posedge clock) begin
    rvalid_a <= req_a;
    rdata_a  <= {18'h0, addr_a[15:2]};
    rvalid_b <= req_b;
    rdata_b  <= {18'h0, addr_b[15:2]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [15:0] pc);
    return {18'h0, pc[15:2]};
  endfunction

  // Reference model: each requested word becomes visible to decode two cycles after its
  // request; delivery order is the plain PC sequence of the current stream.
  int          cyc;
  logic [15:0] m_req_pc, m_pop_pc;
  int          ready_at[$];

  task automatic model_init(input logic [15:0] start);
    cyc      = 0;
    m_req_pc = start;
    m_pop_pc = start;
    ready_at.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [15:0] rpc);
    logic exp_valid, exp_req;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    exp_req   = !rv && (ready_at.size() < 4);
    exp_valid = (ready_at.size() > 0) && (ready_at[0] <= cyc);
    chk("imem_req", req_a, exp_req);
    if (exp_req) chk("imem_addr", addr_a, m_req_pc);
    chk("if_valid", valid_a, exp_valid);
    if (exp_valid) begin
      chk("if_pc", pc_a, m_pop_pc);
      chk("if_instr", instr_a, word_of(m_pop_pc));
      chk("if_pc_plus4", p4_a, m_pop_pc + 16'd4);
    end else begin
      chk("if_pc_empty", pc_a, 16'h0);
      chk("if_instr_empty", instr_a, 32'h0);
    end
    if (!rv && exp_valid && rdy) begin
      void'(ready_at.pop_front());
      m_pop_pc = m_pop_pc + 16'd4;
    end
    if (exp_req) begin
      ready_at.push_back(cyc + 2);
      m_req_pc = m_req_pc + 16'd4;
    end
    if (rv) begin
      ready_at.delete();
      m_req_pc = rpc & 16'hFFFC;
      m_pop_pc = rpc & 16'hFFFC;
    end
    cyc++;
  endtask

  typedef struct {
    logic        exp_req;
    logic [15:0] exp_addr_a;
    logic [15:0] exp_addr_b;
    logic        exp_valid;
    logic [15:0] exp_pc_a;
    logic [15:0] exp_pc_b;
    logic [15:0] exp_p4_b;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming from reset, if_ready held high; dut_b starts at 0xFFF8 and wraps.
    tbl[0] = '{1'b1, 16'h0000, 16'hFFF8, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 16'h0004, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 16'h0008, 16'h0000, 1'b1, 16'h0000, 16'hFFF8, 16'hFFFC};
    tbl[3] = '{1'b1, 16'h000C, 16'h0004, 1'b1, 16'h0004, 16'hFFFC, 16'h0000};
    tbl[4] = '{1'b1, 16'h0010, 16'h0008, 1'b1, 16'h0008, 16'h0000, 16'h0004};
    tbl[5] = '{1'b1, 16'h0014, 16'h000C, 1'b1, 16'h000C, 16'h0004, 16'h0008};

    reset = 1'b1;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    tick();
    chk("reset_valid", valid_a, 1'b0);
    chk("reset_req", req_a, 1'b0);
    chk("reset_addr_b", addr_b, 16'hFFF8);
    chk("reset_pc", pc_a, 16'h0);
    do_reset();

    for (int k = 0; k < 6; k++) begin
      if_ready = 1'b1;
      redirect_valid = 1'b0;
      #1;
      chk("t_req_a", req_a, tbl[k].exp_req);
      chk("t_req_b", req_b, tbl[k].exp_req);
      chk("t_addr_a", addr_a, tbl[k].exp_addr_a);
      chk("t_addr_b", addr_b, tbl[k].exp_addr_b);
      chk("t_valid_a", valid_a, tbl[k].exp_valid);
      chk("t_valid_b", valid_b, tbl[k].exp_valid);
      chk("t_pc_a", pc_a, tbl[k].exp_pc_a);
      chk("t_pc_b", pc_b, tbl[k].exp_pc_b);
      chk("t_instr_a", instr_a, tbl[k].exp_valid ? word_of(tbl[k].exp_pc_a) : 32'h0);
      chk("t_instr_b", instr_b, tbl[k].exp_valid ? word_of(tbl[k].exp_pc_b) : 32'h0);
      chk("t_p4_a", p4_a, tbl[k].exp_valid ? tbl[k].exp_pc_a + 16'd4 : 16'h0);
      chk("t_p4_b", p4_b, tbl[k].exp_p4_b);
      tick();
    end

    // Back-pressure: queue fills to DEPTH, then drains without loss or duplicates.
    do_reset();
    model_init(16'h0000);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      tick();
    end

    // Redirect while a response is returning: that response is dropped.
    do_reset();
    model_init(16'h0000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      tick();
    end
    chk("stale_rvalid_present", rvalid_a, 1'b1);
    drive(1'b1, 1'b1, 16'h0042);
    tick();
    drive(1'b1, 1'b0, 16'h0);
    chk("redir_r1_valid", valid_a, 1'b0);
    tick();
    drive(1'b1, 1'b0, 16'h0);
    chk("redir_r2_valid", valid_a, 1'b0);
    tick();
    drive(1'b1, 1'b0, 16'h0);
    chk("redir_r3_valid", valid_a, 1'b1);
    chk("redir_r3_pc", pc_a, 16'h0040);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      tick();
    end

    // Two consecutive redirects: the second one wins.
    drive(1'b1, 1'b1, 16'h0100);
    tick();
    drive(1'b1, 1'b1, 16'h0200);
    tick();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b0, 16'h0);
    chk("b2b_first_pc", pc_a, 16'h0200);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      tick();
    end

    // Randomised traffic against the model.
    do_reset();
    model_init(16'h0000);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 16'($urandom));
      tick();
    end

    // Reset in mid-stream with a partly filled queue.
    do_reset();
    model_init(16'h0000);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      tick();
    end
    chk("pre_reset_valid", valid_a, 1'b1);
    reset = 1'b1;
    if_ready = 1'b1;
    tick();
    chk("mid_reset_valid", valid_a, 1'b0);
    chk("mid_reset_req", req_a, 1'b0);
    chk("mid_reset_addr", addr_a, 16'h0000);
    chk("mid_reset_pc", pc_a, 16'h0000);
`ifdef RISCV_FETCH_STATS_EN
    chk("stat_fetched_rst", sf_a, 32'h0);
    chk("stat_flushes_rst", sfl_a, 32'h0);
    chk("stat_stalls_rst", ss_a, 32'h0);
`endif
    tick();
    reset = 1'b0;
    model_init(16'h0000);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
